// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete
// on three lanes, in-order retire of up to two entries per cycle.
module reorder_buffer #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_has_dr,
  input  logic [5:0]       alloc_dr,
  input  logic [5:0]       alloc_old_dr,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_rob_num,
  input  logic             complete_valid_0,
  input  logic             complete_valid_1,
  input  logic             complete_valid_2,
  input  logic [IDX_W-1:0] ROB_complete_0,
  input  logic [IDX_W-1:0] ROB_complete_1,
  input  logic [IDX_W-1:0] ROB_complete_2,
  input  logic [31:0]      new_dr_data_0,
  input  logic [31:0]      new_dr_data_1,
  input  logic [31:0]      new_dr_data_2,
  output logic             retire_valid_0,
  output logic             retire_valid_1,
  output logic [31:0]      retire_pc_0,
  output logic [31:0]      retire_pc_1,
  output logic             retire_has_dr_0,
  output logic             retire_has_dr_1,
  output logic [5:0]       retire_dr_0,
  output logic [5:0]       retire_dr_1,
  output logic [31:0]      retire_data_0,
  output logic [31:0]      retire_data_1,
  output logic [5:0]       retire_free_dr_0,
  output logic [5:0]       retire_free_dr_1,
  output logic [IDX_W:0]   rob_count
);

  localparam int CW = IDX_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        has_dr;
    logic [5:0]  dr;
    logic [5:0]  old_dr;
  } info_t;

  info_t            info_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;

  logic [CW-1:0]    head_q;
  logic [CW-1:0]    tail_q;
  logic [CW-1:0]    cnt_q;

  logic [IDX_W-1:0] h0;
  logic [IDX_W-1:0] h1;
  logic [IDX_W-1:0] t0;
  logic             fire0;
  logic             fire1;
  logic             do_alloc;
  logic [1:0]       nret;

  logic [2:0]       cv;
  logic [2:0]       hit;
  logic [IDX_W-1:0] ci [3];
  logic [31:0]      cd [3];

  logic [1:0]       rv_q;
  info_t            ret0_q;
  info_t            ret1_q;
  logic [31:0]      rdat0_q;
  logic [31:0]      rdat1_q;

  assign h0 = head_q[IDX_W-1:0];
  assign h1 = h0 + IDX_W'(1);
  assign t0 = tail_q[IDX_W-1:0];

  assign alloc_ready   = (cnt_q != CW'(DEPTH));
  assign alloc_rob_num = t0;
  assign do_alloc      = alloc_valid && alloc_ready;

  assign fire0 = valid_q[h0] && done_q[h0];
  assign fire1 = fire0 && valid_q[h1] && done_q[h1];
  assign nret  = {1'b0, fire0} + {1'b0, fire1};

  assign cv    = {complete_valid_2, complete_valid_1, complete_valid_0};
  assign ci[0] = ROB_complete_0;
  assign ci[1] = ROB_complete_1;
  assign ci[2] = ROB_complete_2;
  assign cd[0] = new_dr_data_0;
  assign cd[1] = new_dr_data_1;
  assign cd[2] = new_dr_data_2;

  // Completions to entries not yet allocated are dropped
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = cv[i] && valid_q[ci[i]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      rv_q    <= '0;
      ret0_q  <= '0;
      ret1_q  <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hit[i]) done_q[ci[i]] <= 1'b1;
      end
      if (fire0) begin
        valid_q[h0] <= 1'b0;
        done_q[h0]  <= 1'b0;
      end
      if (fire1) begin
        valid_q[h1] <= 1'b0;
        done_q[h1]  <= 1'b0;
      end
      if (do_alloc) begin
        valid_q[t0] <= 1'b1;
        done_q[t0]  <= 1'b0;
      end
      head_q  <= head_q + CW'(nret);
      tail_q  <= tail_q + CW'(do_alloc);
      cnt_q   <= cnt_q + CW'(do_alloc) - CW'(nret);
      rv_q    <= {fire1, fire0};
      ret0_q  <= fire0 ? info_q[h0] : '0;
      ret1_q  <= fire1 ? info_q[h1] : '0;
      rdat0_q <= fire0 ? data_q[h0] : '0;
      rdat1_q <= fire1 ? data_q[h1] : '0;
    end
  end

  // Payload needs no reset; descending loop lets lane 0 win duplicates
  always_ff @(posedge clk) begin
    for (int i = 2; i >= 0; i--) begin
      if (hit[i]) data_q[ci[i]] <= cd[i];
    end
    if (do_alloc) begin
      info_q[t0] <= '{pc: alloc_pc, has_dr: alloc_has_dr,
                      dr: alloc_dr, old_dr: alloc_old_dr};
      data_q[t0] <= '0;
    end
  end

  assign retire_valid_0   = rv_q[0];
  assign retire_valid_1   = rv_q[1];
  assign retire_pc_0      = ret0_q.pc;
  assign retire_pc_1      = ret1_q.pc;
  assign retire_has_dr_0  = ret0_q.has_dr;
  assign retire_has_dr_1  = ret1_q.has_dr;
  assign retire_dr_0      = ret0_q.dr;
  assign retire_dr_1      = ret1_q.dr;
  assign retire_free_dr_0 = ret0_q.old_dr;
  assign retire_free_dr_1 = ret1_q.old_dr;
  assign retire_data_0    = rdat0_q;
  assign retire_data_1    = rdat1_q;
  assign rob_count        = cnt_q;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 64-entry reorder buffer sitting directly downstream of the registered complete stage. It allocates entries in program order for dispatch and accepts up to three completions per cycle by ROB number. It retires up to two finished instructions per cycle, in order, presenting the destination register, its value, and the stale physical register to free.

## Interface
- DEPTH, 64, number of entries; power of two
- IDX_W, 6, log2(DEPTH); width of ROB numbers
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- alloc_valid  in  1  dispatch requests one entry this cycle
- alloc_pc  in  32  PC of allocating instruction
- alloc_has_dr  in  1  instruction writes a destination register
- alloc_dr  in  6  new physical destination register
- alloc_old_dr  in  6  previous mapping of the architectural dest, freed at retire
- alloc_ready  out  1  entry available (count < DEPTH); combinational from registered state
- alloc_rob_num  out  IDX_W  index granted when alloc_valid && alloc_ready (= tail index)
- complete_valid_0/1/2  in  1  completion lane valid
- ROB_complete_0/1/2  in  IDX_W  ROB number completing
- new_dr_data_0/1/2  in  32  result value
- retire_valid_0/1  out  1  retire slot valid (registered)
- retire_pc_0/1  out  32  retired PC
- retire_has_dr_0/1  out  1  retired instruction writes a register
- retire_dr_0/1  out  6  physical destination committed
- retire_data_0/1  out  32  committed value
- retire_free_dr_0/1  out  6  old physical register to return to free list
- rob_count  out  IDX_W+1  occupied entries (registered)

## Operation
- Per entry: valid, done, pc, has_dr, dr, old_dr, data.
- head/tail are IDX_W+1 bits with a wrap bit; count = tail − head; full when count == DEPTH, empty when count == 0.
- Allocate: alloc_valid && alloc_ready writes entry[tail] with valid=1, done=0, data=0; tail += 1. alloc_valid while full is ignored, with no state change.
- Complete: each valid lane whose target entry is valid sets done=1 and writes data. Lanes targeting an invalid entry are dropped. Two lanes hitting the same index: the lowest-numbered lane's data wins and done is set once.
- Retire: slot 0 fires if entry[head] is valid and done. Slot 1 fires only if slot 0 fires and entry[head+1] is valid and done. Fired entries are cleared (valid=0, done=0); head advances by 0, 1 or 2.
- Retire outputs hold the fired entries' fields. Non-firing slots drive valid=0 and all fields 0.
- Allocate, complete and retire all update on the same edge. Evaluation uses pre-edge state: alloc_ready does not see same-cycle frees, and retire does not see same-cycle completions.
- Indices wrap from DEPTH−1 to 0. Slot 1 at head index 63 uses entry 0.

## Timing
- Reset (rstn low, asynchronous): all entry valid/done = 0, head = tail = 0, rob_count = 0, all retire_* = 0. alloc_ready = 1 and alloc_rob_num = 0 while in reset and after it.
- Reset asserted mid-operation discards all in-flight entries immediately. Completions arriving at the first edge after release are dropped, because no entry is valid.
- Allocation: alloc_rob_num is valid in the same cycle. The entry is valid after the edge, and rob_count updates at that edge.
- Completion: captured at edge E. The earliest retire evaluation is the cycle after E, so retire_valid rises after edge E+1 (2 edges, complete input → retire output).
- Completing in the same cycle as the allocating edge for that index is dropped; completion must arrive at least one cycle after allocation.
- Throughput: 1 allocate, 3 completes and 2 retires per cycle sustained.

## Test plan
- Reset: assert rstn=0 mid-traffic → all retire_valid=0, rob_count=0, alloc_ready=1, alloc_rob_num=0; allocation after release gets index 0.
- Out-of-order complete: allocate PCs 0x100, 0x104, 0x108 (idx 0..2). Complete idx 2 with 0xC, then idx 1 with 0xB → no retire. Complete idx 0 with 0xA → next: slot0 pc 0x100 data 0xA and slot1 pc 0x104 data 0xB. Following cycle: slot0 pc 0x108 data 0xC.
- Full: 64 allocations with no completion → rob_count=64, alloc_ready=0. A 65th alloc_valid changes nothing. One retire → alloc_ready=1 one cycle later, not in the retire cycle.
- Wrap: advance head to 63. Allocate idx 63 and 0, complete both → same-cycle retire of slot0 idx 63 and slot1 idx 0. Next alloc_rob_num=1.
- Triple complete with duplicate: lanes 0 and 2 complete idx 5 with 0x11 and 0x22, lane 1 completes idx 6 → entry 5 data 0x11. Completion to an unallocated idx 9 is ignored: idx 9 is later allocated with done=0.
- Free-list info: retire entry with has_dr=1, dr=12, old_dr=7 → retire_dr=12, retire_free_dr=7. Entry with has_dr=0 → retire_has_dr=0.
